// File: rtl/reset_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq_pkg
//  Description : Shared types and constants for the reset/ready sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package reset_seq_pkg;

    // Sequencer states, explicitly encoded.
    typedef enum logic [2:0] {
        ASSERT  = 3'd0,
        HOLD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        SOFT    = 3'd4
    } seq_state_t;

    // Width of the saturating restart counter.
    localparam int RESTART_W = 8;

endpackage : reset_seq_pkg
`default_nettype wire

// File: rtl/reset_seq_sync.sv
`default_nettype none
// ============================================================================
//  Module      : reset_seq_sync
//  Description : WIDTH-bit, STAGES-deep flop synchronizer for asynchronous
//                level inputs. Asynchronous active-high reset clears to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_seq_sync #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Index 0 is the first (metastability-catching) flop row.
    logic [STAGES-1:0][WIDTH-1:0] r_sync;

    // Shift the asynchronous inputs through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : reset_seq_sync
`default_nettype wire

// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : reset_sequencer
//  Description : Combines N_READY asynchronous ready sources, waits for them
//                to be stably high, then releases N_STAGE reset domains in
//                index order with a fixed gap. Any ready drop re-asserts all
//                domains at once; a software request forces a minimum-width
//                reset pulse before the sequence restarts.
//  Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int N_READY     = 2,
    parameter int N_STAGE     = 3,
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 1024,
    parameter int STAGE_GAP   = 16,
    parameter int SOFT_MIN    = 64
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [N_READY-1:0]   READY_IN,
    input  logic                 SOFT_RESET_REQ,
    output logic [N_STAGE-1:0]   STAGE_RESET_n,
    output logic                 ALL_RUN,
    output logic [RESTART_W-1:0] RESTART_CNT
);

    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int GAP_W  = $clog2(STAGE_GAP) + 1;
    localparam int SOFT_W = $clog2(SOFT_MIN) + 1;
    localparam int STG_W  = $clog2(N_STAGE) + 1;

    // Terminal values: a counter reaching *_LAST completes its interval on
    // the current edge.
    localparam logic [HOLD_W-1:0]    c_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0]     c_GAP_LAST  = GAP_W'(STAGE_GAP - 1);
    localparam logic [SOFT_W-1:0]    c_SOFT_LAST = SOFT_W'(SOFT_MIN - 1);
    localparam logic [STG_W-1:0]     c_STG_ALL   = STG_W'(N_STAGE);
    localparam logic [RESTART_W-1:0] c_CNT_SAT   = {RESTART_W{1'b1}};

    logic [N_READY-1:0]   w_ready_sync;
    logic                 w_all_ready;

    seq_state_t           r_state;
    logic [HOLD_W-1:0]    r_hold_cnt;
    logic [GAP_W-1:0]     r_gap_cnt;
    logic [SOFT_W-1:0]    r_soft_cnt;
    logic [STG_W-1:0]     r_stage_idx;   // number of stages already released
    logic [N_STAGE-1:0]   r_stage_n;
    logic                 r_all_run;
    logic [RESTART_W-1:0] r_restart_cnt;

    reset_seq_sync #(
        .WIDTH  (N_READY),
        .STAGES (SYNC_STAGES)
    ) u_ready_sync (
        .clk (CLK),
        .rst (RESET),
        .i_d (READY_IN),
        .o_q (w_ready_sync)
    );

    assign w_all_ready = &w_ready_sync;

    // Sequencer FSM with counters and registered outputs; a ready drop always
    // takes priority over a software request.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= ASSERT;
            r_hold_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_soft_cnt    <= '0;
            r_stage_idx   <= '0;
            r_stage_n     <= '0;
            r_all_run     <= 1'b0;
            r_restart_cnt <= '0;
        end else begin
            case (r_state)
                ASSERT: begin
                    r_stage_n <= '0;
                    r_all_run <= 1'b0;
                    if (w_all_ready) begin
                        r_state    <= HOLD;
                        r_hold_cnt <= '0;
                    end
                end

                HOLD: begin
                    if (!w_all_ready) begin
                        r_state   <= ASSERT;
                        r_stage_n <= '0;
                        r_all_run <= 1'b0;
                    end else if (SOFT_RESET_REQ) begin
                        r_hold_cnt <= '0;
                    end else if (r_hold_cnt == c_HOLD_LAST) begin
                        r_state     <= RELEASE;
                        r_stage_n   <= N_STAGE'(1);
                        r_stage_idx <= STG_W'(1);
                        r_gap_cnt   <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end

                RELEASE: begin
                    if (!w_all_ready) begin
                        r_state   <= ASSERT;
                        r_stage_n <= '0;
                        r_all_run <= 1'b0;
                    end else if (SOFT_RESET_REQ) begin
                        r_state    <= SOFT;
                        r_stage_n  <= '0;
                        r_all_run  <= 1'b0;
                        r_soft_cnt <= '0;
                    end else if (r_gap_cnt == c_GAP_LAST) begin
                        r_gap_cnt <= '0;
                        if (r_stage_idx == c_STG_ALL) begin
                            r_state   <= RUN;
                            r_all_run <= 1'b1;
                        end else begin
                            // Stages open strictly in index order and stay open.
                            r_stage_n   <= r_stage_n | (N_STAGE'(1) << r_stage_idx);
                            r_stage_idx <= r_stage_idx + 1'b1;
                        end
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                RUN: begin
                    if (!w_all_ready) begin
                        r_state   <= ASSERT;
                        r_stage_n <= '0;
                        r_all_run <= 1'b0;
                        if (r_restart_cnt != c_CNT_SAT) begin
                            r_restart_cnt <= r_restart_cnt + 1'b1;
                        end
                    end else if (SOFT_RESET_REQ) begin
                        r_state    <= SOFT;
                        r_stage_n  <= '0;
                        r_all_run  <= 1'b0;
                        r_soft_cnt <= '0;
                    end
                end

                SOFT: begin
                    r_stage_n <= '0;
                    r_all_run <= 1'b0;
                    if (!w_all_ready) begin
                        r_state <= ASSERT;
                    end else if (r_soft_cnt == c_SOFT_LAST) begin
                        r_state    <= HOLD;
                        r_hold_cnt <= '0;
                    end else begin
                        r_soft_cnt <= r_soft_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state   <= ASSERT;
                    r_stage_n <= '0;
                    r_all_run <= 1'b0;
                end
            endcase
        end
    end

    assign STAGE_RESET_n = r_stage_n;
    assign ALL_RUN       = r_all_run;
    assign RESTART_CNT   = r_restart_cnt;

endmodule : reset_sequencer
`default_nettype wire
